// File: rtl/seq_mult_ctrl.sv
// Sequential shift-and-add multiplier controller: fetches operands from external A/B registers,
// iterates one multiplier bit per cycle. Optional macro SEQ_MULT_EARLY_EXIT_EN ends CALC once the multiplier is zero.
module seq_mult_ctrl #(
   parameter int DATA_SIZE = 8
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     start_i,
   output logic                     unload_o,
   input  logic [DATA_SIZE-1:0]     a_i,
   input  logic [DATA_SIZE-1:0]     b_i,
   output logic [2*DATA_SIZE-1:0]   product_o,
   output logic                     busy_o,
   output logic                     done_o
);

   localparam int CNT_W = $clog2(DATA_SIZE + 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      FETCH = 3'd1,
      CAPT  = 3'd2,
      CALC  = 3'd3,
      DONE  = 3'd4
   } state_t;

   state_t                   state_r;
   logic [DATA_SIZE-1:0]     mcand_r;
   logic [DATA_SIZE-1:0]     mplier_r;
   logic [2*DATA_SIZE-1:0]   acc_r;
   logic [CNT_W-1:0]         cnt_r;
   logic [2*DATA_SIZE-1:0]   product_r;
   logic                     unload_r;
   logic                     busy_r;
   logic                     done_r;

   logic [2*DATA_SIZE-1:0]   addend_s;
   logic [2*DATA_SIZE-1:0]   acc_next_s;

`ifndef SEQ_MULT_EARLY_EXIT_EN
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_SIZE - 1);
   logic                     last_iter_s;
`endif

   // Partial product for the current multiplier bit, weighted by the iteration count
   always_comb begin
      addend_s = {(2*DATA_SIZE){1'b0}};
      if (mplier_r[0]) begin
         addend_s = {{DATA_SIZE{1'b0}}, mcand_r} << cnt_r;
      end else begin
         addend_s = {(2*DATA_SIZE){1'b0}};
      end
      acc_next_s = acc_r + addend_s;
   end

`ifndef SEQ_MULT_EARLY_EXIT_EN
   assign last_iter_s = (cnt_r == LAST_CNT);
`endif

   // Controller FSM with datapath registers and registered outputs
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_r   <= IDLE;
         mcand_r   <= {DATA_SIZE{1'b0}};
         mplier_r  <= {DATA_SIZE{1'b0}};
         acc_r     <= {(2*DATA_SIZE){1'b0}};
         cnt_r     <= {CNT_W{1'b0}};
         product_r <= {(2*DATA_SIZE){1'b0}};
         unload_r  <= 1'b0;
         busy_r    <= 1'b0;
         done_r    <= 1'b0;
      end else begin
         unload_r <= 1'b0;
         done_r   <= 1'b0;
         case (state_r)
            IDLE: begin
               if (start_i) begin
                  state_r  <= FETCH;
                  unload_r <= 1'b1;
                  busy_r   <= 1'b1;
               end else begin
                  state_r  <= IDLE;
               end
            end
            FETCH: begin
               state_r <= CAPT;
            end
            // Operand registers present fresh data one cycle after the unload strobe
            CAPT: begin
               mcand_r  <= a_i;
               mplier_r <= b_i;
               acc_r    <= {(2*DATA_SIZE){1'b0}};
               cnt_r    <= {CNT_W{1'b0}};
               state_r  <= CALC;
            end
            CALC: begin
`ifdef SEQ_MULT_EARLY_EXIT_EN
               if (mplier_r == {DATA_SIZE{1'b0}}) begin
                  product_r <= acc_r;
                  done_r    <= 1'b1;
                  state_r   <= DONE;
               end else begin
                  acc_r    <= acc_next_s;
                  mplier_r <= mplier_r >> 1;
                  cnt_r    <= cnt_r + CNT_W'(1);
                  state_r  <= CALC;
               end
`else
               acc_r    <= acc_next_s;
               mplier_r <= mplier_r >> 1;
               cnt_r    <= cnt_r + CNT_W'(1);
               if (last_iter_s) begin
                  product_r <= acc_next_s;
                  done_r    <= 1'b1;
                  state_r   <= DONE;
               end else begin
                  state_r   <= CALC;
               end
`endif
            end
            DONE: begin
               busy_r  <= 1'b0;
               state_r <= IDLE;
            end
            default: begin
               busy_r  <= 1'b0;
               state_r <= IDLE;
            end
         endcase
      end
   end

   assign unload_o  = unload_r;
   assign product_o = product_r;
   assign busy_o    = busy_r;
   assign done_o    = done_r;

endmodule
